mlp_layer_sequencer: RTL and testbench

Upstream controller for the output layer. It accepts one hidden-layer activation vector per transaction and prepends the bias input. It then serialises the vector one element per cycle into the layer's input_value/input_index/start/valid/output_en control interface. Index and data are aligned to the layer's 1-cycle synchronous weight-memory read, and a single done pulse is issued once the layer has registered its outputs.

---
 rtl/mlp_pkg.sv | 17 +
 rtl/mlp_pipe_delay.sv | 27 ++
 rtl/mlp_layer_sequencer.sv | 110 +++++++++++
 tb/tb_mlp_layer_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath: sequencer state encoding and
// the Q8.8 fixed-point constants used by every layer.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT,
    FIN
  } seq_state_t;

  localparam int Q_FRAC_BITS  = 8;
  localparam int Q_ONE        = 1 << Q_FRAC_BITS;
  localparam int BIAS_DEFAULT = Q_ONE;

endpackage

// File: rtl/mlp_pipe_delay.sv
// Parameterised register delay line with enable and asynchronous reset;
// used to align data and strobes behind the weight-memory read address.
module mlp_pipe_delay #(
  parameter int DATA_W = 1,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] pipe_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) pipe_q[s] <= '0;
    end else if (en) begin
      pipe_q[0] <= d;
      for (int s = 1; s < STAGES; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign q = pipe_q[STAGES-1];

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Serialises one bias-prefixed activation vector per transaction into the
// output layer's start/valid/output_en interface, then pulses done.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int N_INPUTS = 2 + 1,
  parameter int IN_WIDTH = 16,
  parameter int BIAS_VAL = BIAS_DEFAULT,
  parameter int MAC_LAT  = 1,
  localparam int IDX_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [(N_INPUTS-1)*IN_WIDTH-1:0] in_data_flat,
  input  logic                             wr_busy,
  output logic signed [IN_WIDTH-1:0]       input_value,
  output logic [IDX_W-1:0]                 input_index,
  output logic                             start,
  output logic                             valid,
  output logic                             output_en,
  output logic                             done,
  output logic                             busy
);

  localparam int CNT_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAC_LAT);

  seq_state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [(N_INPUTS-1)*IN_WIDTH-1:0] data_q;
  logic accept;

  logic signed [IN_WIDTH-1:0] value_p0;
  logic [IN_WIDTH-1:0]        value_p1;
  logic issue_p0, start_p0, valid_p0, oe_p0, done_p0;

  assign in_ready = (state == IDLE) && !wr_busy && !rst;
  assign accept   = in_valid && in_ready;

  // Drain runs MAC_LAT+1 cycles because the last term reaches the MAC one
  // cycle after its index was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      idx   <= (state == ISSUE && idx != LAST_IDX) ? idx + 1'b1 : '0;
      cnt   <= (state == DRAIN) ? cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) data_q <= in_data_flat;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   if (idx == LAST_IDX) state_nx = DRAIN;
      DRAIN:   if (cnt == LAST_CNT) state_nx = OUTPUT;
      OUTPUT:  state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: decode of the address-issue cycle
  always_comb begin
    issue_p0 = (state == ISSUE);
    start_p0 = issue_p0 && (idx == '0);
    valid_p0 = issue_p0 && (idx != '0);
    oe_p0    = (state == DRAIN) && (cnt == LAST_CNT);
    done_p0  = (state == OUTPUT);
    value_p0 = IN_WIDTH'(BIAS_VAL);
    for (int k = 1; k < N_INPUTS; k++) begin
      if (idx == IDX_W'(k)) value_p0 = data_q[(k-1)*IN_WIDTH +: IN_WIDTH];
    end
  end

  assign input_index = idx;

  // Stage p1: one cycle behind the index, matching the registered weight read
  mlp_pipe_delay #(.DATA_W(IN_WIDTH), .STAGES(1)) u_value_dly (
    .clk (clk),
    .rst (rst),
    .en  (issue_p0),
    .d   (value_p0),
    .q   (value_p1)
  );

  mlp_pipe_delay #(.DATA_W(4), .STAGES(1)) u_strobe_dly (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   ({start_p0, valid_p0, oe_p0, done_p0}),
    .q   ({start, valid, output_en, done})
  );

  assign input_value = value_p1;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: default and wide configurations,
// plus a small behavioural output layer driven by the default instance.
module tb_mlp_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  logic               in_valid = 1'b0;
  logic               wr_busy  = 1'b0;
  logic [31:0]        in_data  = '0;
  logic               in_ready;
  logic signed [15:0] iv;
  logic [1:0]         ix;
  logic               st, vl, oe, dn, bz;

  mlp_layer_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_flat(in_data), .wr_busy(wr_busy), .input_value(iv),
    .input_index(ix), .start(st), .valid(vl), .output_en(oe),
    .done(dn), .busy(bz)
  );

  logic               in_valid5 = 1'b0;
  logic [63:0]        in_data5  = '0;
  logic               in_ready5;
  logic signed [15:0] iv5;
  logic [2:0]         ix5;
  logic               st5, vl5, oe5, dn5, bz5;

  mlp_layer_sequencer #(.N_INPUTS(5), .MAC_LAT(3)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data_flat(in_data5), .wr_busy(1'b0), .input_value(iv5),
    .input_index(ix5), .start(st5), .valid(vl5), .output_en(oe5),
    .done(dn5), .busy(bz5)
  );

  // Behavioural two-neuron output layer, all weights 1, registered weight read
  logic signed [15:0] w_mem [2][3];
  logic signed [15:0] w_q   [2];
  logic signed [31:0] acc   [2];
  logic signed [31:0] outs  [2];

  initial begin
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 3; i++) w_mem[n][i] = 16'sd1;
  end

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      w_q[n] <= w_mem[n][ix];
      if (st)      acc[n] <= iv * w_q[n];
      else if (vl) acc[n] <= acc[n] + iv * w_q[n];
      if (oe)      outs[n] <= acc[n];
    end
  end

  task automatic check_val(input string tag, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Called at a negedge where the handshake is armed; the next posedge is T.
  task automatic run_txn(input int a, input int b, input bit keep, input int na, input int nb);
    int v;
    @(posedge clk);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) begin
        if (keep) in_data = {16'(nb), 16'(na)};
        else      in_valid = 1'b0;
      end
      check_val($sformatf("idx T+%0d", j),   int'(ix), (j <= 3) ? j - 1 : 0);
      check_val($sformatf("start T+%0d", j), int'(st), int'(j == 2));
      check_val($sformatf("valid T+%0d", j), int'(vl), int'(j == 3 || j == 4));
      check_val($sformatf("oe T+%0d", j),    int'(oe), int'(j == 6));
      check_val($sformatf("done T+%0d", j),  int'(dn), int'(j == 7));
      check_val($sformatf("busy T+%0d", j),  int'(bz), int'(j <= 7));
      check_val($sformatf("rdy T+%0d", j),   int'(in_ready), int'(j == 8));
      if (j >= 2) begin
        v = (j == 2) ? 256 : (j == 3) ? a : b;
        check_val($sformatf("value T+%0d", j), int'(iv), v);
      end
    end
  endtask

  task automatic offer(input int a, input int b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = {16'(b), 16'(a)};
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check_val("offer timeout", 0, 1);
  endtask

  initial begin
    int v, seen;

    // Reset state
    #12;
    check_val("rst in_ready", int'(in_ready), 0);
    check_val("rst in_ready5", int'(in_ready5), 0);
    check_val("rst outputs", int'({st, vl, oe, dn, bz}), 0);
    check_val("rst idx", int'(ix), 0);
    check_val("rst value", int'(iv), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single vector {10,-3}; layer sum 256+10-3
    offer(10, -3);
    run_txn(10, -3, 1'b0, 0, 0);
    check_val("layer n0 sum", outs[0], 263);

    // Back-to-back with in_valid held high
    offer(1, 2);
    run_txn(1, 2, 1'b1, 3, 4);
    check_val("b2b in_valid", int'(in_valid), 1);
    run_txn(3, 4, 1'b0, 0, 0);

    // wr_busy blocks acceptance
    @(negedge clk);
    wr_busy  = 1'b1;
    in_data  = {16'(-7), 16'(20)};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("wrb rdy %0d", k), int'(in_ready), 0);
      @(negedge clk);
      check_val($sformatf("wrb strobes %0d", k), int'({st, vl, oe, dn, bz}), 0);
    end
    wr_busy = 1'b0;
    #1;
    check_val("wrb release rdy", int'(in_ready), 1);
    run_txn(20, -7, 1'b0, 0, 0);

    // Reset in the middle of a transaction
    offer(7, 8);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("pre-rst valid", int'(vl), 1);
    rst = 1'b1;
    #1;
    check_val("mid-rst idx", int'(ix), 0);
    check_val("mid-rst value", int'(iv), 0);
    check_val("mid-rst strobes", int'({st, vl, oe, dn, bz}), 0);
    check_val("mid-rst rdy", int'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen = seen | int'(oe | dn | bz);
    end
    check_val("post-rst quiet", seen, 0);
    offer(5, -6);
    run_txn(5, -6, 1'b0, 0, 0);

    // Integrated layer: {0x0100, 0x0200}, all weights 1
    offer(16'h0100, 16'h0200);
    run_txn(16'h0100, 16'h0200, 1'b0, 0, 0);
    check_val("layer n0", outs[0], 32'h0400);
    check_val("layer n1", outs[1], 32'h0400);

    // N_INPUTS=5, MAC_LAT=3, vector {1,2,3,4}
    @(negedge clk);
    in_data5  = {16'd4, 16'd3, 16'd2, 16'd1};
    in_valid5 = 1'b1;
    #1;
    check_val("w5 rdy", int'(in_ready5), 1);
    @(posedge clk);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 1) in_valid5 = 1'b0;
      check_val($sformatf("w5 idx T+%0d", j),   int'(ix5), (j <= 5) ? j - 1 : 0);
      check_val($sformatf("w5 start T+%0d", j), int'(st5), int'(j == 2));
      check_val($sformatf("w5 valid T+%0d", j), int'(vl5), int'(j >= 3 && j <= 6));
      check_val($sformatf("w5 oe T+%0d", j),    int'(oe5), int'(j == 10));
      check_val($sformatf("w5 done T+%0d", j),  int'(dn5), int'(j == 11));
      check_val($sformatf("w5 busy T+%0d", j),  int'(bz5), int'(j <= 11));
      check_val($sformatf("w5 rdy T+%0d", j),   int'(in_ready5), int'(j == 12));
      if (j >= 2) begin
        v = (j == 2) ? 256 : (j <= 6) ? j - 2 : 4;
        check_val($sformatf("w5 value T+%0d", j), int'(iv5), v);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
